mc_ctrl_fsm: RTL

Multi-cycle main control unit for the CPU core. It decodes the 6-bit opcode field of the latched instruction and sequences the shared datapath through fetch, decode, execute, memory and writeback. It sits between the instruction register and the datapath muxes and enables. It also owns the request/ready handshake to the unified instruction/data memory port.

---
 rtl/cpu_ctrl_pkg.sv | 71 +++++++
 rtl/mc_ctrl_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
//   Shared definitions for the multi-cycle CPU control path. The ALU control,
//   the datapath and mc_ctrl_fsm all import this package.
//   Contents:
//     - opcode localparams (instruction bits [31:26])
//     - state_t     : 4-bit main-control state encoding
//     - alu_op_t    : main control -> ALU control operation class
//     - pc_src_t    : PC input mux select
//     - alu_src_b_t : ALU operand B mux select
//     - op_supported(): opcode legality check
//   Optional feature macro: MC_CTRL_ADDI_EN (ADDI instruction support).
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Encodings are visible on the debug state port, so they are fixed.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    // True for every opcode the core decodes in this build.
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI:                             ok = 1'b1;
`endif
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle main control unit. Sequences the shared datapath through
//   fetch / decode / execute / memory / writeback and owns the req/ready
//   handshake to the unified instruction+data memory port.
//
//   Optional feature macro: MC_CTRL_ADDI_EN
//     defined     : ADDI (001000) runs through ADDIEX -> ADDIWB
//     not defined : ADDI is an illegal opcode; states 10/11 are unreachable
//
//   Ports
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset
//     op[5:0]    in   opcode (IR[31:26]), valid from DECODE onward
//     zero       in   ALU zero flag, used in BRANCH
//     mem_ready  in   memory completes current access this cycle
//     mem_req    out  memory access request
//     mem_we     out  write strobe, qualifies mem_req
//     iord       out  memory address select: 0 PC, 1 ALUOut
//     ir_we      out  instruction register load
//     pc_we      out  PC load
//     pc_src     out  PC mux: 00 ALU, 01 ALUOut, 10 jump target
//     alu_src_a  out  ALU A mux: 0 PC, 1 reg A
//     alu_src_b  out  ALU B mux: 00 B, 01 4, 10 imm, 11 imm<<2
//     alu_op     out  00 add, 01 sub, 10 funct-decoded
//     reg_we     out  register-file write
//     reg_dst    out  write register: 0 rt, 1 rd
//     mem_to_reg out  write data: 0 ALUOut, 1 MDR
//     illegal    out  one-cycle pulse in DECODE on unsupported opcode
//     state[3:0] out  current state for trace
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    state_t cur;
    state_t nxt;

    // The state register is the only storage in this block.
    always_ff @(posedge clk) begin
        if (rst) cur <= state_t'(RESET_STATE);
        else     cur <= nxt;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      nxt = S_ADDIEX;
`endif
                    default:      nxt = S_FETCH;   // illegal opcode
                endcase
            end
            // Only LW/SW reach MEMADR, so SW alone needs distinguishing.
            S_MEMADR: nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  if (mem_ready) nxt = S_FETCH;
            S_EXEC:   nxt = S_ALUWB;
            S_ALUWB:  nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: nxt = S_ADDIWB;
            S_ADDIWB: nxt = S_FETCH;
`endif
            default:  nxt = S_FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode. Everything defaults to 0; reset forces all outputs low
    // in the same cycle so an in-flight memory request is dropped at once.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        state      = 4'd0;

        if (!rst) begin
            state = cur;
            case (cur)
                S_FETCH: begin
                    // PC + 4 computed while the fetch is outstanding; IR and
                    // PC load together on the completing cycle.
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: begin
                    // Speculative branch target into ALUOut.
                    alu_src_b = SRCB_IMM_SH2;
                    illegal   = !op_supported(op);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ALUWB: begin
                    reg_we  = 1'b1;
                    reg_dst = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_we     = zero;
                end
                S_JUMP: begin
                    pc_src = PC_JUMP;
                    pc_we  = 1'b1;
                end
`ifdef MC_CTRL_ADDI_EN
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_ADDIWB: begin
                    reg_we = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
